// File: rtl/tm16xx_frame_driver.sv
// tm16xx_frame_driver: NUM_GRIDS-byte frame buffer plus two-wire serial engine for TM1640/TM1638-class LED drivers.
// Optional macro TM_AUTO_REFRESH_EN retransmits the buffer after REFRESH_CYCLES idle clocks.
//
// state | meaning
// IDLE  | lines high, frame bytes accepted, waiting for tlast/start
// CMD1  | data-set command (0x40) transaction
// CMD2  | start + address command, continues into DATA without stop
// DATA  | buffer bytes 0..NUM_GRIDS-1, then stop
// CMD3  | display-control command transaction
module tm16xx_frame_driver #(
  parameter int NUM_GRIDS      = 16,
  parameter int CLK_DIV        = 4,
  parameter int START_ADDR     = 0,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  input  logic       start,
  input  logic [2:0] brightness,
  input  logic       disp_on,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic       SCL,
  output logic       SDA
);

  if (NUM_GRIDS < 1 || NUM_GRIDS > 16 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
    $error("tm16xx_frame_driver: parameter out of range");
  end

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD1 = 3'd1;
  localparam logic [2:0] ST_CMD2 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CMD3 = 3'd4;

  localparam logic [1:0] PH_START = 2'd0;
  localparam logic [1:0] PH_BIT   = 2'd1;
  localparam logic [1:0] PH_STOP  = 2'd2;

  localparam logic [7:0]  CMD_DATA_SET = 8'h40;
  localparam logic [7:0]  CMD_ADDR     = 8'hC0 | 8'(START_ADDR % 16);
  localparam logic [3:0]  LAST_IDX     = 4'(NUM_GRIDS - 1);
  localparam logic [4:0]  PTR_FULL     = 5'(NUM_GRIDS);
  localparam logic [15:0] DIV_LOAD     = 16'(CLK_DIV - 1);

  logic [2:0]  state, state_n;
  logic [1:0]  ph, ph_n;
  logic [2:0]  bit_cnt, bit_n;
  logic        half, half_n;
  logic [1:0]  stop_cnt, stop_n;
  logic [3:0]  byte_idx, idx_n;
  logic [15:0] div_cnt;
  logic [2:0]  bright_q;
  logic        on_q;
  logic [4:0]  wr_ptr;
  logic [7:0]  buf_mem [16];
  logic [7:0]  tx_byte;
  logic        scl_n, sda_n;
  logic        tick, accept, auto_req, frame_req, frame_end;

  assign busy     = (state != ST_IDLE);
  assign s_tready = (state == ST_IDLE);
  assign accept   = s_tvalid && s_tready;
  assign tick     = busy && (div_cnt == 16'd0);

`ifdef TM_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_LOAD = 32'(REFRESH_CYCLES - 1);
  logic [31:0] refresh_cnt;

  // Reloaded throughout every frame, so the idle gap is measured from done.
  always_ff @(posedge clk) begin
    if (rst || busy)
      refresh_cnt <= REFRESH_LOAD;
    else if (refresh_cnt != 32'd0)
      refresh_cnt <= refresh_cnt - 32'd1;
  end

  assign auto_req = (refresh_cnt == 32'd0);
`else
  assign auto_req = 1'b0;
`endif

  assign frame_req = !busy && ((accept && s_tlast) || start || auto_req);

  always_comb begin
    state_n   = state;
    ph_n      = ph;
    bit_n     = bit_cnt;
    half_n    = half;
    stop_n    = stop_cnt;
    idx_n     = byte_idx;
    frame_end = 1'b0;
    if (!busy) begin
      if (frame_req) begin
        state_n = ST_CMD1;
        ph_n    = PH_START;
        bit_n   = 3'd0;
        half_n  = 1'b0;
        stop_n  = 2'd0;
        idx_n   = 4'd0;
      end
    end else if (tick) begin
      case (ph)
        PH_START: begin
          ph_n   = PH_BIT;
          bit_n  = 3'd0;
          half_n = 1'b0;
        end
        PH_BIT: begin
          if (!half) begin
            half_n = 1'b1;
          end else if (bit_cnt != 3'd7) begin
            bit_n  = bit_cnt + 3'd1;
            half_n = 1'b0;
          end else begin
            bit_n  = 3'd0;
            half_n = 1'b0;
            case (state)
              ST_CMD2: begin
                state_n = ST_DATA;
                idx_n   = 4'd0;
              end
              ST_DATA: begin
                if (byte_idx != LAST_IDX) begin
                  idx_n = byte_idx + 4'd1;
                end else begin
                  ph_n   = PH_STOP;
                  stop_n = 2'd0;
                end
              end
              default: begin
                ph_n   = PH_STOP;
                stop_n = 2'd0;
              end
            endcase
          end
        end
        PH_STOP: begin
          if (stop_cnt != 2'd2) begin
            stop_n = stop_cnt + 2'd1;
          end else begin
            ph_n = PH_START;
            case (state)
              ST_CMD1: state_n = ST_CMD2;
              ST_DATA: state_n = ST_CMD3;
              default: begin
                state_n   = ST_IDLE;
                frame_end = 1'b1;
              end
            endcase
          end
        end
        default: begin
          state_n   = ST_IDLE;
          frame_end = 1'b1;
        end
      endcase
    end
  end

  // Line levels are derived from the next sequencer state so SCL/SDA leave a flop.
  always_comb begin
    case (state_n)
      ST_CMD1: tx_byte = CMD_DATA_SET;
      ST_CMD2: tx_byte = CMD_ADDR;
      ST_DATA: tx_byte = buf_mem[idx_n];
      ST_CMD3: tx_byte = {4'h8, on_q, bright_q};
      default: tx_byte = 8'hFF;
    endcase
    scl_n = 1'b1;
    sda_n = 1'b1;
    if (state_n != ST_IDLE) begin
      case (ph_n)
        PH_START: begin
          scl_n = 1'b1;
          sda_n = 1'b0;
        end
        PH_BIT: begin
          scl_n = half_n;
          sda_n = tx_byte[bit_n];
        end
        PH_STOP: begin
          scl_n = (stop_n != 2'd0);
          sda_n = (stop_n == 2'd2);
        end
        default: begin
          scl_n = 1'b1;
          sda_n = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ph        <= PH_START;
      bit_cnt   <= 3'd0;
      half      <= 1'b0;
      stop_cnt  <= 2'd0;
      byte_idx  <= 4'd0;
      div_cnt   <= 16'd0;
      bright_q  <= 3'd0;
      on_q      <= 1'b0;
      done      <= 1'b0;
      SCL       <= 1'b1;
      SDA       <= 1'b1;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      bit_cnt  <= bit_n;
      half     <= half_n;
      stop_cnt <= stop_n;
      byte_idx <= idx_n;
      done     <= frame_end;
      SCL      <= scl_n;
      SDA      <= sda_n;
      if (frame_req) begin
        bright_q <= brightness;
        on_q     <= disp_on;
        div_cnt  <= DIV_LOAD;
      end else if (busy) begin
        div_cnt <= tick ? DIV_LOAD : div_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 5'd0;
      frame_err <= 1'b0;
      for (int i = 0; i < 16; i++)
        buf_mem[i] <= 8'h00;
    end else if (accept) begin
      if (wr_ptr == PTR_FULL) begin
        frame_err <= 1'b1;
      end else begin
        buf_mem[wr_ptr[3:0]] <= s_tdata;
        wr_ptr               <= wr_ptr + 5'd1;
      end
      if (s_tlast)
        wr_ptr <= 5'd0;
    end
  end

endmodule
